// File: rtl/cache_ctrl_burst_if.sv
// Bundle of core-request, cache-array and memory handshake signals for cache_ctrl_burst.
// master = controller side, slave = core/array/memory side.
interface cache_ctrl_burst_if #(
    parameter int WAYS  = 2,
    parameter int BEATS = 4
);
    localparam int WAY_W  = (WAYS  > 2) ? $clog2(WAYS)  : 1;
    localparam int BEAT_W = (BEATS > 2) ? $clog2(BEATS) : 1;

    logic              req_valid;
    logic              req_type;
    logic              req_ready;
    logic              hit;
    logic              victim_dirty;
    logic [WAY_W-1:0]  victim_way;
    logic [BEAT_W-1:0] beat_idx;
    logic              mem_req_valid;
    logic              mem_req_write;
    logic              mem_req_ready;
    logic              mem_wr_valid;
    logic              mem_wr_ready;
    logic              mem_rd_valid;
    logic              read_en_cache;
    logic              write_en_cache;
    logic              cache_wb_rd;
    logic              refill;
    logic              tag_update;
    logic              done_cache;
    logic              error;

    modport master (
        input  req_valid, req_type, hit, victim_dirty,
               mem_req_ready, mem_wr_ready, mem_rd_valid,
        output req_ready, victim_way, beat_idx, mem_req_valid, mem_req_write,
               mem_wr_valid, read_en_cache, write_en_cache, cache_wb_rd,
               refill, tag_update, done_cache, error
    );

    modport slave (
        output req_valid, req_type, hit, victim_dirty,
               mem_req_ready, mem_wr_ready, mem_rd_valid,
        input  req_ready, victim_way, beat_idx, mem_req_valid, mem_req_write,
               mem_wr_valid, read_en_cache, write_en_cache, cache_wb_rd,
               refill, tag_update, done_cache, error
    );
endinterface

// File: rtl/cache_ctrl_burst.sv
// N-way write-back/write-allocate cache controller with multi-beat line transfers.
// Optional memory-wait watchdog enabled by defining CACHE_CTRL_TIMEOUT_EN.
module cache_ctrl_burst #(
    parameter int WAYS    = 2,
    parameter int BEATS   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    cache_ctrl_burst_if.master bus
);
    localparam int WAY_W  = (WAYS  > 2) ? $clog2(WAYS)  : 1;
    localparam int BEAT_W = (BEATS > 2) ? $clog2(BEATS) : 1;
    localparam logic [WAY_W-1:0]  LAST_WAY  = WAY_W'(WAYS - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    // Elaboration-time parameter sanity checks.
    if (WAYS < 2) begin : g_bad_ways
        $error("cache_ctrl_burst: WAYS must be at least 2");
    end
    if ((BEATS < 1) || ((BEATS & (BEATS - 1)) != 0)) begin : g_bad_beats
        $error("cache_ctrl_burst: BEATS must be a power of 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("cache_ctrl_burst: TIMEOUT must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COMPARE = 3'd1,
        S_WB_REQ  = 3'd2,
        S_WB_DATA = 3'd3,
        S_RF_REQ  = 3'd4,
        S_RF_DATA = 3'd5,
        S_UPDATE  = 3'd6
    } state_t;

    state_t            state_q,  state_d;
    logic [BEAT_W-1:0] beat_q,   beat_d;
    logic [WAY_W-1:0]  victim_q, victim_d;
    logic              type_q,   type_d;

`ifdef CACHE_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    logic [WD_W-1:0] wdog_q, wdog_d;
`endif

    logic req_ready_s, mem_req_valid_s, mem_req_write_s, mem_wr_valid_s;
    logic read_en_s, write_en_s, wb_rd_s, refill_s, tag_update_s;
    logic done_s, error_s, stall_s;

    // Next-state, counters and Mealy output decode.
    always_comb begin
        state_d         = state_q;
        beat_d          = beat_q;
        victim_d        = victim_q;
        type_d          = type_q;
        req_ready_s     = 1'b0;
        mem_req_valid_s = 1'b0;
        mem_req_write_s = 1'b0;
        mem_wr_valid_s  = 1'b0;
        read_en_s       = 1'b0;
        write_en_s      = 1'b0;
        wb_rd_s         = 1'b0;
        refill_s        = 1'b0;
        tag_update_s    = 1'b0;
        done_s          = 1'b0;
        error_s         = 1'b0;
        stall_s         = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready_s = 1'b1;
                if (bus.req_valid) begin
                    type_d  = bus.req_type;
                    state_d = S_COMPARE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_COMPARE: begin
                if (bus.hit) begin
                    done_s     = 1'b1;
                    read_en_s  = ~type_q;
                    write_en_s = type_q;
                    state_d    = S_IDLE;
                end else if (bus.victim_dirty) begin
                    state_d = S_WB_REQ;
                end else begin
                    state_d = S_RF_REQ;
                end
            end
            S_WB_REQ: begin
                mem_req_valid_s = 1'b1;
                mem_req_write_s = 1'b1;
                if (bus.mem_req_ready) begin
                    beat_d  = '0;
                    state_d = S_WB_DATA;
                end else begin
                    stall_s = 1'b1;
                end
            end
            S_WB_DATA: begin
                mem_wr_valid_s = 1'b1;
                wb_rd_s        = 1'b1;
                if (!bus.mem_wr_ready) begin
                    stall_s = 1'b1;
                end else if (beat_q == LAST_BEAT) begin
                    beat_d  = '0;
                    state_d = S_RF_REQ;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            S_RF_REQ: begin
                mem_req_valid_s = 1'b1;
                if (bus.mem_req_ready) begin
                    beat_d  = '0;
                    state_d = S_RF_DATA;
                end else begin
                    stall_s = 1'b1;
                end
            end
            S_RF_DATA: begin
                if (!bus.mem_rd_valid) begin
                    stall_s = 1'b1;
                end else begin
                    write_en_s = 1'b1;
                    refill_s   = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = S_UPDATE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            S_UPDATE: begin
                tag_update_s = 1'b1;
                victim_d     = (victim_q == LAST_WAY) ? '0 : victim_q + WAY_W'(1);
                state_d      = S_COMPARE;
            end
            default: begin
                beat_d  = '0;
                state_d = S_IDLE;
            end
        endcase

`ifdef CACHE_CTRL_TIMEOUT_EN
        // Any non-stall cycle (entry, handshake, other state) clears the watchdog.
        if (!stall_s) begin
            wdog_d = '0;
        end else if (wdog_q == WD_LAST) begin
            wdog_d  = '0;
            error_s = 1'b1;
            done_s  = 1'b1;
            beat_d  = '0;
            state_d = S_IDLE;
        end else begin
            wdog_d = wdog_q + WD_W'(1);
        end
`endif
    end

    // State, beat, victim pointer and latched request type registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            beat_q   <= '0;
            victim_q <= '0;
            type_q   <= 1'b0;
`ifdef CACHE_CTRL_TIMEOUT_EN
            wdog_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            victim_q <= victim_d;
            type_q   <= type_d;
`ifdef CACHE_CTRL_TIMEOUT_EN
            wdog_q   <= wdog_d;
`endif
        end
    end

    assign bus.req_ready      = req_ready_s;
    assign bus.victim_way     = victim_q;
    assign bus.beat_idx       = beat_q;
    assign bus.mem_req_valid  = mem_req_valid_s;
    assign bus.mem_req_write  = mem_req_write_s;
    assign bus.mem_wr_valid   = mem_wr_valid_s;
    assign bus.read_en_cache  = read_en_s;
    assign bus.write_en_cache = write_en_s;
    assign bus.cache_wb_rd    = wb_rd_s;
    assign bus.refill         = refill_s;
    assign bus.tag_update     = tag_update_s;
    assign bus.done_cache     = done_s;
    assign bus.error          = error_s;
endmodule

// File: tb/tb_cache_ctrl_burst.sv
// Self-checking bench for cache_ctrl_burst: directed plan items plus randomized
// transactions checked cycle-by-cycle against a phase-level reference model.
module tb_cache_ctrl_burst;
    localparam int WAYS    = 3;
    localparam int BEATS   = 4;
    localparam int TIMEOUT = 8;
    localparam int N       = 256;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_ctrl_burst_if #(.WAYS(WAYS), .BEATS(BEATS)) bus ();

    cache_ctrl_burst #(.WAYS(WAYS), .BEATS(BEATS), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    int model_ptr = 0;
    int last_done;
    int e_done, e_upd;
    bit rq_a[N], wr_a[N], rd_a[N];
    bit e_wb[N], e_rf[N], e_mreq[N], e_mwr[N];
    int e_beat[N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Memory behaviour per cycle: 0 = zero wait, 1 = random stalls, 2 = two wr stalls on beat 1.
    task automatic gen_stream(input int mode);
        int rq_run = 0, wr_run = 0, rd_run = 0;
        for (int c = 0; c < N; c++) begin
            if (mode == 1 && c < 64) begin
                rq_a[c] = ($urandom_range(3, 0) != 0) || (rq_run >= 3);
                wr_a[c] = ($urandom_range(3, 0) != 0) || (wr_run >= 3);
                rd_a[c] = ($urandom_range(3, 0) != 0) || (rd_run >= 3);
                rq_run = rq_a[c] ? 0 : rq_run + 1;
                wr_run = wr_a[c] ? 0 : wr_run + 1;
                rd_run = rd_a[c] ? 0 : rd_run + 1;
            end else begin
                rq_a[c] = 1'b1;
                wr_a[c] = 1'b1;
                rd_a[c] = 1'b1;
            end
        end
        if (mode == 2) begin
            wr_a[4] = 1'b0;
            wr_a[5] = 1'b0;
        end
    endtask

    // Walk the transaction phase by phase, consuming memory-ready cycles.
    task automatic build_model(input bit is_hit, input bit dirty);
        int t;
        for (int c = 0; c < N; c++) begin
            e_wb[c] = 1'b0; e_rf[c] = 1'b0; e_mreq[c] = 1'b0; e_mwr[c] = 1'b0; e_beat[c] = 0;
        end
        e_upd = -1;
        if (is_hit) begin
            e_done = 1;
        end else begin
            t = 2;
            if (dirty) begin
                while (!rq_a[t] && t < N - 8) begin e_mreq[t] = 1'b1; e_mwr[t] = 1'b1; t++; end
                e_mreq[t] = 1'b1; e_mwr[t] = 1'b1; t++;
                for (int b = 0; b < BEATS; b++) begin
                    while (!wr_a[t] && t < N - 8) begin e_wb[t] = 1'b1; e_beat[t] = b; t++; end
                    e_wb[t] = 1'b1; e_beat[t] = b; t++;
                end
            end
            while (!rq_a[t] && t < N - 8) begin e_mreq[t] = 1'b1; t++; end
            e_mreq[t] = 1'b1; t++;
            for (int b = 0; b < BEATS; b++) begin
                while (!rd_a[t] && t < N - 8) begin e_beat[t] = b; t++; end
                e_beat[t] = b; e_rf[t] = 1'b1; t++;
            end
            e_upd  = t;
            e_done = t + 1;
        end
    endtask

    task automatic run_txn(input bit wr, input bit is_hit, input bit dirty, input int mode);
        int vexp;
        gen_stream(mode);
        build_model(is_hit, dirty);
        last_done = -1;
        for (int c = 0; c <= e_done && c < N; c++) begin
            bus.req_valid     = (c == 0);
            bus.req_type      = (c == 0) ? wr : 1'($urandom_range(1, 0));
            bus.hit           = (c == 1) ? is_hit : (c == e_done) ? 1'b1 : 1'($urandom_range(1, 0));
            bus.victim_dirty  = (c == 1) ? dirty : 1'($urandom_range(1, 0));
            bus.mem_req_ready = rq_a[c];
            bus.mem_wr_ready  = wr_a[c];
            bus.mem_rd_valid  = rd_a[c];
            @(negedge clk);
            vexp = (!is_hit && c == e_done) ? (model_ptr + 1) % WAYS : model_ptr;
            check("req_ready", 32'(bus.req_ready), 32'(c == 0));
            check("done_cache", 32'(bus.done_cache), 32'(c == e_done));
            check("error", 32'(bus.error), 32'd0);
            check("read_en", 32'(bus.read_en_cache), 32'(c == e_done && !wr));
            check("write_en", 32'(bus.write_en_cache), 32'(e_rf[c] || (c == e_done && wr)));
            check("refill", 32'(bus.refill), 32'(e_rf[c]));
            check("cache_wb_rd", 32'(bus.cache_wb_rd), 32'(e_wb[c]));
            check("mem_wr_valid", 32'(bus.mem_wr_valid), 32'(e_wb[c]));
            check("mem_req_valid", 32'(bus.mem_req_valid), 32'(e_mreq[c]));
            if (e_mreq[c]) check("mem_req_write", 32'(bus.mem_req_write), 32'(e_mwr[c]));
            check("tag_update", 32'(bus.tag_update), 32'(c == e_upd));
            check("beat_idx", 32'(bus.beat_idx), 32'(e_beat[c]));
            check("victim_way", 32'(bus.victim_way), 32'(vexp));
            if (bus.done_cache === 1'b1 && last_done < 0) last_done = c;
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        if (!is_hit) model_ptr = (model_ptr + 1) % WAYS;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_type = 1'b0; bus.hit = 1'b0; bus.victim_dirty = 1'b0;
        bus.mem_req_ready = 1'b0; bus.mem_wr_ready = 1'b0; bus.mem_rd_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_done", 32'(bus.done_cache), 32'd0);
        check("rst_beat", 32'(bus.beat_idx), 32'd0);
        check("rst_victim", 32'(bus.victim_way), 32'd0);
        check("rst_mem_req", 32'(bus.mem_req_valid), 32'd0);
        check("rst_error", 32'(bus.error), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Read hit, then IDLE again one cycle after done.
        run_txn(1'b0, 1'b1, 1'b0, 0);
        check("hit_latency", 32'(last_done), 32'd1);
        @(negedge clk);
        check("hit_ready_again", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;

        // Write, clean miss, zero-wait.
        run_txn(1'b1, 1'b0, 1'b0, 0);
        check("clean_miss_latency", 32'(last_done), 32'd8);

        // Dirty miss with two write-back stalls on beat 1.
        run_txn(1'b0, 1'b0, 1'b1, 2);
        check("dirty_stall_latency", 32'(last_done), 32'd15);

        // Four consecutive misses walk the round-robin pointer.
        for (int i = 0; i < 4; i++) run_txn(1'b0, 1'b0, 1'b0, 0);

        // Reset while refilling beat 2.
        gen_stream(0);
        for (int c = 0; c <= 5; c++) begin
            bus.req_valid = (c == 0); bus.req_type = 1'b0; bus.hit = 1'b0; bus.victim_dirty = 1'b0;
            bus.mem_req_ready = 1'b1; bus.mem_wr_ready = 1'b1; bus.mem_rd_valid = 1'b1;
            if (c == 5) rst = 1'b1;
            @(negedge clk);
            if (c == 5) begin
                check("mid_rst_beat2", 32'(bus.beat_idx), 32'd2);
                check("mid_rst_refill", 32'(bus.refill), 32'd1);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(bus.req_ready), 32'd1);
        check("post_rst_beat", 32'(bus.beat_idx), 32'd0);
        check("post_rst_done", 32'(bus.done_cache), 32'd0);
        check("post_rst_victim", 32'(bus.victim_way), 32'd0);
        model_ptr = 0;
        @(posedge clk); #1;

`ifdef CACHE_CTRL_TIMEOUT_EN
        // mem_req_ready held low in RF_REQ until the watchdog fires.
        for (int c = 0; c <= 9; c++) begin
            bus.req_valid = (c == 0); bus.req_type = 1'b0; bus.hit = 1'b0; bus.victim_dirty = 1'b0;
            bus.mem_req_ready = (c < 2); bus.mem_wr_ready = 1'b1; bus.mem_rd_valid = 1'b1;
            @(negedge clk);
            if (c >= 2) begin
                check("wd_error", 32'(bus.error), 32'(c == 9));
                check("wd_done", 32'(bus.done_cache), 32'(c == 9));
            end
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("wd_idle", 32'(bus.req_ready), 32'd1);
        check("wd_victim", 32'(bus.victim_way), 32'(model_ptr));
        @(posedge clk); #1;
        run_txn(1'b1, 1'b0, 1'b0, 0);
`endif

        // Randomized transactions with random memory stalls.
        for (int i = 0; i < 40; i++) begin
            run_txn(1'($urandom_range(1, 0)), ($urandom_range(2, 0) == 0),
                    1'($urandom_range(1, 0)), 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
